// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART register map, bit positions, baud divider and RX state enum
package uart_pkg;

   localparam logic [7:0] CFG_OFF    = 8'h00;
   localparam logic [7:0] RXDATA_OFF = 8'h04;
   localparam logic [7:0] INST_OFF   = 8'h08;
   localparam logic [7:0] STATUS_OFF = 8'h0C;

   localparam int CFG_EN   = 0;
   localparam int CFG_BAUD = 1;
   localparam int CFG_IRQ  = 2;

   localparam int INST_CONSUME = 0;
   localparam int INST_CLR_IRQ = 1;
   localparam int INST_CLR_ERR = 2;

   localparam int ST_BUSY  = 0;
   localparam int ST_VALID = 1;
   localparam int ST_OVR   = 2;
   localparam int ST_FERR  = 3;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // Bit period in clocks minus one; fast selects 115200 baud, otherwise 9600.
   function automatic logic [31:0] baud_div(input logic [31:0] clk_hz, input logic fast);
      return clk_hz / (fast ? 32'd115200 : 32'd9600) - 32'd1;
   endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for the asynchronous serial line (resets to idle high)
module sync2 (
   input  logic clock,
   input  logic nRst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with bus register interface, sticky flags and level interrupt
module uart_rx #(
   parameter int unsigned sys_clk = 50000000
) (
   input  logic        clock,
   input  logic        nRst,
   input  logic        HSEL,
   input  logic        HWRITE,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        interrupt,
   input  logic        RX
);

   import uart_pkg::*;

   rx_state_t   state, next_state;
   logic        rx_s;
   logic [2:0]  cfg;
   logic [7:0]  rx_data, shift;
   logic        valid, overrun, ferr;
   logic [31:0] cnt, div, half;
   logic [2:0]  idx;
   logic        cnt_clr, sample, done;
   logic        bus_wr, cfg_wr, inst_wr;
   logic        consume, clr_irq, clr_err;
   logic        store, drop;
   logic        unused_bits;

   sync2 u_sync2 (
      .clock (clock),
      .nRst  (nRst),
      .d     (RX),
      .q     (rx_s)
   );

   assign div  = baud_div(sys_clk, cfg[CFG_BAUD]);
   assign half = div >> 1;

   assign bus_wr  = HSEL && HWRITE;
   assign cfg_wr  = bus_wr && (HADDR[7:0] == CFG_OFF);
   assign inst_wr = bus_wr && (HADDR[7:0] == INST_OFF);
   assign consume = inst_wr && HWDATA[INST_CONSUME];
   assign clr_irq = inst_wr && HWDATA[INST_CLR_IRQ];
   assign clr_err = inst_wr && HWDATA[INST_CLR_ERR];

   // A consume landing on the completion cycle frees the slot for the new byte.
   assign store = done && (!valid || consume);
   assign drop  = done && valid && !consume;

   assign unused_bits = &{1'b0, HADDR[31:8], HWDATA[31:3]};

   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) state <= RX_IDLE;
      else       state <= next_state;
   end

   // Compares use >= so a mid-frame switch to the shorter divider cannot run the counter past it.
   always_comb begin
      next_state = state;
      cnt_clr    = 1'b0;
      sample     = 1'b0;
      done       = 1'b0;
      if (!cfg[CFG_EN]) begin
         next_state = RX_IDLE;
         cnt_clr    = 1'b1;
      end else begin
         case (state)
            RX_IDLE: begin
               cnt_clr = 1'b1;
               if (!rx_s) next_state = RX_START;
            end
            RX_START: begin
               if (cnt >= half) begin
                  cnt_clr    = 1'b1;
                  next_state = rx_s ? RX_IDLE : RX_DATA;
               end
            end
            RX_DATA: begin
               if (cnt >= div) begin
                  cnt_clr = 1'b1;
                  sample  = 1'b1;
                  if (idx == 3'd7) next_state = RX_STOP;
               end
            end
            RX_STOP: begin
               if (cnt >= div) begin
                  cnt_clr    = 1'b1;
                  done       = 1'b1;
                  next_state = RX_IDLE;
               end
            end
            default: next_state = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
      end else begin
         cnt <= cnt_clr ? 32'd0 : cnt + 32'd1;
         if (state != RX_DATA) idx <= '0;
         else if (sample)      idx <= idx + 3'd1;
         if (sample) shift[idx] <= rx_s;
      end
   end

   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         cfg       <= '0;
         rx_data   <= '0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
         ferr      <= 1'b0;
         interrupt <= 1'b0;
      end else begin
         if (cfg_wr) cfg <= HWDATA[2:0];
         if (store) begin
            rx_data <= shift;
            valid   <= 1'b1;
         end else if (consume) begin
            valid <= 1'b0;
         end
         overrun <= (overrun && !clr_err) || drop;
         ferr    <= (ferr && !clr_err) || (store && !rx_s);
         if (store && cfg[CFG_IRQ]) interrupt <= 1'b1;
         else if (clr_irq)          interrupt <= 1'b0;
      end
   end

   always_comb begin
      HRDATA = '0;
      if (nRst) begin
         case (HADDR[7:0])
            CFG_OFF:    HRDATA = {29'd0, cfg};
            RXDATA_OFF: HRDATA = {24'd0, rx_data};
            STATUS_OFF: HRDATA = {28'd0, ferr, overrun, valid, state != RX_IDLE};
            default:    HRDATA = '0;
         endcase
      end
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter sys_clk, default 50000000, system clock frequency in Hz.
REQ-002 clock  input  1  system clock, rising-edge active.
REQ-003 nRst  input  1  reset, asynchronous, active-low.
REQ-004 HSEL  input  1  slave select.
REQ-005 HWRITE  input  1  write strobe, qualified by HSEL.
REQ-006 HADDR  input  32  register address; only HADDR[7:0] is decoded.
REQ-007 HWDATA  input  32  write data.
REQ-008 HRDATA  output  32  read data, combinational from HADDR[7:0].
REQ-009 interrupt  output  1  receive-complete interrupt, level, sticky.
REQ-010 RX  input  1  asynchronous serial line, idle high.

Function
REQ-011 The register map SHALL be: 0x00 cfg (RW; bit0 enable, bit1 baud select 0=9600/1=115200, bit2 interrupt enable); 0x04 rx_data (RO, bits[7:0]); 0x08 inst (WO; bit0 consume byte, bit1 clear interrupt, bit2 clear errors); 0x0C status (RO; bit0 busy, bit1 valid, bit2 overrun, bit3 framing error).
REQ-012 A cfg write SHALL occur when HSEL&&HWRITE and offset 0x00, storing HWDATA[2:0]; the upper bits read 0.
REQ-013 Writes to 0x04, 0x0C and unmapped offsets SHALL have no effect; reads of 0x08 and unmapped offsets SHALL return 0.
REQ-014 The bit period count SHALL be div = sys_clk/baud - 1 (32-bit), and the half period SHALL be div>>1.
REQ-015 RX SHALL pass through a two-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-016 The FSM SHALL have four states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-017 RX_IDLE->RX_START SHALL occur when cfg.enable=1 and rx_s=0; the counter clears.
REQ-018 In RX_START, at count==half the FSM SHALL go to RX_DATA if rx_s=0 (counter clears, bit index 0); otherwise it SHALL return to RX_IDLE (glitch rejected).
REQ-019 In RX_DATA, at each count==div the FSM SHALL sample rx_s into shift bit[index], LSB first; after index 7 it SHALL go to RX_STOP.
REQ-020 In RX_STOP, at count==div the FSM SHALL go to RX_IDLE and complete the byte.
REQ-021 Completion with valid=0: rx_data SHALL take the byte, valid SHALL go to 1, and ferr SHALL be set if the stop sample is 0; the byte is stored in both cases.
REQ-022 Completion with valid=1: the byte SHALL be discarded, overrun SHALL be set, and rx_data SHALL be unchanged.
REQ-023 interrupt SHALL rise one cycle after a completion that stores a byte when cfg bit2=1; it SHALL clear only on an inst bit1 write.
REQ-024 An inst bit0 write SHALL clear valid; if it coincides with a completion, the completion wins (valid stays 1, new byte stored, no overrun).
REQ-025 An inst bit2 write SHALL clear overrun and ferr; a simultaneous set wins.
REQ-026 status.busy SHALL be 1 whenever the FSM is not in RX_IDLE.
REQ-027 Clearing cfg.enable mid-frame SHALL force RX_IDLE on the next edge, discarding the partial byte; flags are unchanged.
REQ-028 A baud change mid-frame SHALL take effect at the next counter compare; the frame content is then undefined.

Reset
REQ-029 On nRst low: FSM=RX_IDLE; counters, shift register, cfg, rx_data, valid, overrun, ferr and interrupt SHALL all be 0; synchronizer flops SHALL be 1.
REQ-030 HRDATA SHALL be 0 while nRst is low.

Structure
REQ-031 Package uart_pkg SHALL hold the register offsets, cfg/inst/status bit positions, the baud divider function, and the RX state enum, shared with the UART transmitter.
REQ-032 The synchronizer SHALL be the sub-module sync2; no other sub-module is used.

Verification (sys_clk=50 MHz, div 5207 / 433)
REQ-033 Enable 115200 with irq enabled, drive frame 0xA5 -> status.valid=1, rx_data=0xA5, interrupt=1, ferr=0.
REQ-034 1-cycle-to-200-cycle low pulse on RX at 9600 -> FSM returns to RX_IDLE, valid stays 0.
REQ-035 Two frames 0x11 then 0x22 without consume -> rx_data=0x11, overrun=1; inst=0x4 clears it.
REQ-036 Frame 0x3C with stop bit 0 -> rx_data=0x3C, valid=1, ferr=1.
REQ-037 inst bit0 write on the exact completion cycle of 0x55 -> valid=1, rx_data=0x55, overrun=0.
REQ-038 nRst asserted mid-RX_DATA, then frame 0x81 -> all status 0 after reset; 0x81 then received correctly.
